// File: rtl/fft_spi_pkg.sv
// rtl/fft_spi_pkg.sv - shared defaults and state encoding for the SPI frame controller
package fft_spi_pkg;

   localparam int FRAME_BITS_DEF = 1024;
   localparam int CLK_DIV_DEF    = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SYNC  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/fft_spi_controller_clk_gen.sv
// rtl/fft_spi_controller_clk_gen.sv - sck divider producing rising/falling half-tick strobes
module spi_clk_gen
   import fft_spi_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEF
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   output logic sck_o,
   output logic rise_tick_o,
   output logic fall_tick_o
);

   localparam int DW = $clog2(CLK_DIV);

   logic [DW-1:0] div_q;
   logic          sck_q;
   logic          tick;

   // A half-tick fires on the last clk of each CLK_DIV window; it tells the
   // FSM which sck edge the coming clk edge will produce.
   assign tick        = en_i && (div_q == DW'(CLK_DIV - 1));
   assign rise_tick_o = tick && !sck_q;
   assign fall_tick_o = tick && sck_q;
   assign sck_o       = sck_q;

   // Divider counter and sck toggle; held cleared (sck low) while disabled.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_q <= '0;
         sck_q <= 1'b0;
      end else if (!en_i) begin
         div_q <= '0;
         sck_q <= 1'b0;
      end else if (tick) begin
         div_q <= '0;
         sck_q <= !sck_q;
      end else begin
         div_q <= div_q + 1'b1;
      end
   end

endmodule

// File: rtl/fft_spi_controller.sv
// rtl/fft_spi_controller.sv - mode 0 SPI controller shifting one FRAME_BITS frame per start
module fft_spi_controller
   import fft_spi_pkg::*;
#(
   parameter int FRAME_BITS = FRAME_BITS_DEF,
   parameter int CLK_DIV    = CLK_DIV_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [FRAME_BITS-1:0] tx_frame_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [FRAME_BITS-1:0] rx_frame_o,
   output logic                  sck_o,
   output logic                  spi_rst_o,
   output logic                  copi_o,
   input  logic                  cipo_i
);

   localparam int CW = $clog2(FRAME_BITS + 1);

   state_e                state_q;
   logic [FRAME_BITS-1:0] tx_sr_q;
   logic [FRAME_BITS-1:0] rx_sr_q;
   logic [FRAME_BITS-1:0] rx_frame_q;
   logic [CW-1:0]         bit_cnt_q;
   logic [CW-1:0]         bit_cnt_d;
   logic                  busy_q;
   logic                  done_q;
   logic                  spi_rst_q;
   logic                  copi_q;
   logic                  clk_en;
   logic                  rise_tick;
   logic                  fall_tick;

   assign clk_en    = (state_q == SYNC) || (state_q == SHIFT);
   assign bit_cnt_d = bit_cnt_q + 1'b1;

   spi_clk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_gen (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .en_i        (clk_en),
      .sck_o       (sck_o),
      .rise_tick_o (rise_tick),
      .fall_tick_o (fall_tick)
   );

   // Frame sequencer: accept, one sck period of clocked reset, shift, report.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         tx_sr_q    <= '0;
         rx_sr_q    <= '0;
         rx_frame_q <= '0;
         bit_cnt_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         spi_rst_q  <= 1'b1;
         copi_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               spi_rst_q <= 1'b1;
               copi_q    <= 1'b0;
               if (start_i) begin
                  tx_sr_q   <= tx_frame_i;
                  bit_cnt_q <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= SYNC;
               end
            end
            SYNC: begin
               if (fall_tick) begin
                  spi_rst_q <= 1'b0;
                  copi_q    <= tx_sr_q[FRAME_BITS-1];
                  state_q   <= SHIFT;
               end
            end
            SHIFT: begin
               if (rise_tick) begin
                  rx_sr_q <= {rx_sr_q[FRAME_BITS-2:0], cipo_i};
               end
               if (fall_tick) begin
                  bit_cnt_q <= bit_cnt_d;
                  if (bit_cnt_q != CW'(FRAME_BITS - 1)) begin
                     tx_sr_q <= {tx_sr_q[FRAME_BITS-2:0], 1'b0};
                     copi_q  <= tx_sr_q[FRAME_BITS-2];
                  end else begin
                     // Last falling edge: publish the frame so done and
                     // rx_frame appear together in the DONE cycle.
                     copi_q     <= 1'b0;
                     spi_rst_q  <= 1'b1;
                     done_q     <= 1'b1;
                     rx_frame_q <= rx_sr_q;
                     state_q    <= DONE;
                  end
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign rx_frame_o = rx_frame_q;
   assign spi_rst_o  = spi_rst_q;
   assign copi_o     = copi_q;

endmodule

// File: tb/tb_fft_spi_controller.sv
// tb/tb_fft_spi_controller.sv - scoreboard bench: loopback, peripheral model, start and reset corners
module tb_fft_spi_controller;

   localparam int BFB  = 1024;
   localparam int BDIV = 4;
   localparam int SFB  = 8;
   localparam int SDIV = 2;
   localparam int BLAT = 2 * BDIV * (BFB + 1);
   localparam int SLAT = 2 * SDIV * (SFB + 1);

   logic clk = 1'b0;
   always #5 clk = !clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int errors = 0;
   int checks = 0;

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // large instance, looped back
   logic           b_rst_n, b_start, b_busy, b_done, b_sck, b_spi_rst, b_copi, b_cipo;
   logic [BFB-1:0] b_tx, b_rx;
   assign b_cipo = b_copi;

   fft_spi_controller #(.FRAME_BITS(BFB), .CLK_DIV(BDIV)) u_big (
      .clk_i(clk), .rst_ni(b_rst_n), .start_i(b_start), .tx_frame_i(b_tx),
      .busy_o(b_busy), .done_o(b_done), .rx_frame_o(b_rx), .sck_o(b_sck),
      .spi_rst_o(b_spi_rst), .copi_o(b_copi), .cipo_i(b_cipo));

   // small instance, against a peripheral model
   logic           s_rst_n, s_start, s_busy, s_done, s_sck, s_spi_rst, s_copi, s_cipo;
   logic [SFB-1:0] s_tx, s_rx;

   fft_spi_controller #(.FRAME_BITS(SFB), .CLK_DIV(SDIV)) u_small (
      .clk_i(clk), .rst_ni(s_rst_n), .start_i(s_start), .tx_frame_i(s_tx),
      .busy_o(s_busy), .done_o(s_done), .rx_frame_o(s_rx), .sck_o(s_sck),
      .spi_rst_o(s_spi_rst), .copi_o(s_copi), .cipo_i(s_cipo));

   // peripheral: preload while spi_rst, sample on sck rise, advance on sck fall
   logic [7:0] p_pat = 8'h00, p_out = 8'h00, p_in = 8'h00, fft_input = 8'h00;
   int         p_cnt = 0;
   logic       p_loaded = 1'b0, p_sck_p = 1'b0;

   always @(negedge clk) begin
      p_loaded = 1'b0;
      if (s_spi_rst) begin
         if (p_cnt == SFB) begin
            p_loaded  = 1'b1;
            fft_input = p_in;
         end
         p_cnt = 0;
         p_out = p_pat;
      end else if (s_sck && !p_sck_p) begin
         p_in = {p_in[6:0], s_copi};
         p_cnt++;
      end else if (!s_sck && p_sck_p && p_cnt != 0) begin
         p_out = {p_out[6:0], 1'b0};
      end
      s_cipo  = p_out[7];
      p_sck_p = s_sck;
   end

   // scoreboards
   typedef struct packed {
      logic [7:0] p;
      logic [7:0] q;
   } s_exp_t;

   logic [BFB-1:0] b_exp_q[$];
   s_exp_t         s_exp_q[$];
   logic [BFB-1:0] b_e;
   s_exp_t         s_e;
   bit             b2b = 1'b0;

   int   b_t0 = 0, b_rises = 0;
   logic b_busy_p = 1'b0, b_sck_p = 1'b0;

   always @(negedge clk) begin
      #1;
      if (b_busy && !b_busy_p) begin
         b_t0    = cyc;
         b_rises = 0;
      end
      if (b_sck && !b_sck_p) b_rises++;
      if (b_done) begin
         if (b_exp_q.size() == 0) begin
            chk(1'b0, "big_unexpected_done", 1, 0);
         end else begin
            b_e = b_exp_q.pop_front();
            chk(b_rx == b_e, "big_rx_frame", b_rx[63:0], b_e[63:0]);
            chk(cyc - b_t0 == BLAT, "big_latency", cyc - b_t0, BLAT);
            chk(b_rises == BFB + 1, "big_sck_rises", b_rises, BFB + 1);
            chk(!b_sck && b_spi_rst && b_busy, "big_done_outputs", {b_sck, b_spi_rst, b_busy}, 3'b011);
         end
      end
      b_busy_p = b_busy;
      b_sck_p  = b_sck;
   end

   int   s_t0 = 0, s_rises = 0, low_run = 0;
   bit   gap_chk = 1'b0;
   logic s_busy_p = 1'b0, s_sck_p = 1'b0;

   always @(negedge clk) begin
      #1;
      if (s_busy && !s_busy_p) begin
         if (gap_chk) chk(low_run == 1, "small_busy_gap", low_run, 1);
         gap_chk = 1'b0;
         s_t0    = cyc;
         s_rises = 0;
         low_run = 0;
      end
      if (!s_busy) low_run++;
      if (s_sck && !s_sck_p) s_rises++;
      if (s_done) begin
         if (s_exp_q.size() == 0) begin
            chk(1'b0, "small_unexpected_done", 1, 0);
         end else begin
            s_e = s_exp_q.pop_front();
            chk(s_rx == s_e.p, "small_rx_frame", s_rx, s_e.p);
            chk(fft_input == s_e.q, "small_copi_bits", fft_input, s_e.q);
            chk(p_loaded == 1'b1, "small_fft_loaded", p_loaded, 1);
            chk(cyc - s_t0 == SLAT, "small_latency", cyc - s_t0, SLAT);
            chk(s_rises == SFB + 1, "small_sck_rises", s_rises, SFB + 1);
         end
         if (b2b) gap_chk = 1'b1;
      end
      s_busy_p = s_busy;
      s_sck_p  = s_sck;
   end

   task automatic wait_done_b(input int maxc);
      for (int n = 0; n < maxc; n++) begin
         @(negedge clk);
         if (b_done) return;
      end
      chk(1'b0, "big_done_timeout", 0, 1);
   endtask

   task automatic wait_done_s(input int maxc);
      for (int n = 0; n < maxc; n++) begin
         @(negedge clk);
         if (s_done) return;
      end
      chk(1'b0, "small_done_timeout", 0, 1);
   endtask

   task automatic send_s(input logic [7:0] p, input logic [7:0] q);
      p_pat   = p;
      s_tx    = q;
      s_exp_q.push_back({p, q});
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      wait_done_s(SLAT + 20);
      @(negedge clk);
   endtask

   bit bad;

   initial begin
      b_rst_n = 1'b0; s_rst_n = 1'b0;
      b_start = 1'b1; s_start = 1'b1;
      b_tx = '1; s_tx = 8'hFF;
      bad = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (b_sck || s_sck) bad = 1'b1;
      end
      chk(!bad, "reset_no_sck", bad, 0);
      chk(b_spi_rst && s_spi_rst, "reset_spi_rst", {b_spi_rst, s_spi_rst}, 2'b11);
      chk(!b_copi && !s_copi, "reset_copi", {b_copi, s_copi}, 0);
      chk(!b_busy && !s_busy, "reset_busy", {b_busy, s_busy}, 0);
      chk(!b_done && !s_done, "reset_done", {b_done, s_done}, 0);
      chk(b_rx == '0 && s_rx == '0, "reset_rx_frame", b_rx[63:0] | 64'(s_rx), 0);
      b_start = 1'b0; s_start = 1'b0;
      b_rst_n = 1'b1; s_rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // loopback of an alternating pattern
      b_tx = {256{4'hA}};
      b_exp_q.push_back(b_tx);
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      wait_done_b(BLAT + 20);
      @(negedge clk);

      // MSB-first order against the peripheral
      send_s(8'h3C, 8'h81);
      send_s(8'h5A, 8'hC3);

      // start pulses mid-SHIFT and in DONE are dropped; tx changes do not leak in
      p_pat = 8'hF0;
      s_tx  = 8'h0F;
      s_exp_q.push_back({8'hF0, 8'h0F});
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      repeat (15) @(negedge clk);
      s_tx    = 8'hFF;
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      wait_done_s(SLAT + 20);
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      repeat (10) @(negedge clk);
      chk(!s_busy, "small_ignored_start_busy", s_busy, 0);
      chk(s_exp_q.size() == 0, "small_ignored_start_queue", s_exp_q.size(), 0);

      // start held high: three frames back to back
      p_pat = 8'h66;
      s_tx  = 8'h99;
      repeat (3) s_exp_q.push_back({8'h66, 8'h99});
      b2b     = 1'b1;
      s_start = 1'b1;
      repeat (3) wait_done_s(SLAT + 20);
      s_start = 1'b0;
      b2b     = 1'b0;
      repeat (10) @(negedge clk);
      chk(!s_busy, "small_b2b_stops", s_busy, 0);

      // reset near bit 500, then a clean frame
      b_tx = {32{32'hDEADBEEF}};
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      repeat (2 * BDIV * 501) @(negedge clk);
      b_rst_n = 1'b0;
      #1;
      chk(!b_sck, "midreset_sck", b_sck, 0);
      chk(b_spi_rst, "midreset_spi_rst", b_spi_rst, 1);
      chk(!b_copi && !b_busy && !b_done, "midreset_ctrl", {b_copi, b_busy, b_done}, 0);
      chk(b_rx == '0, "midreset_rx_frame", b_rx[63:0], 0);
      repeat (3) @(negedge clk);
      b_rst_n = 1'b1;
      @(negedge clk);
      b_tx = {32{32'h13579BDF}};
      b_exp_q.push_back(b_tx);
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      wait_done_b(BLAT + 20);
      repeat (5) @(negedge clk);

      chk(b_exp_q.size() == 0, "big_frames_outstanding", b_exp_q.size(), 0);
      chk(s_exp_q.size() == 0, "small_frames_outstanding", s_exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
